// File: rtl/soc_rst_pkg.sv
// Shared types and helpers for the SoC reset/boot sequencer.
// Holds the sequencer state encoding and the counter width function.
package soc_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    RELEASE    = 3'd1,
    FETCH_WAIT = 3'd2,
    RUN        = 3'd3,
    SW_HOLD    = 3'd4
  } rst_state_e;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lock_filter.sv
// Lock synchroniser and debounce filter for the reset sequencer.
// Ports: clk_sys, reset (async high), pll_locked_i -> lock_s, lock_ok.
module lock_filter
  import soc_rst_pkg::*;
#(
  parameter int LOCK_FILTER_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked_i,
  output logic lock_s,
  output logic lock_ok
);

  localparam int FW = cnt_width(LOCK_FILTER_CYCLES, 1, 1);
  localparam logic [FW-1:0] FMAX = FW'(LOCK_FILTER_CYCLES);

  logic [1:0]    sync_q;
  logic [1:0]    sync_d;
  logic [FW-1:0] filt_q;
  logic [FW-1:0] filt_d;

  assign lock_s  = sync_q[1];
  assign lock_ok = (filt_q == FMAX);

  always_comb begin
    sync_d = {sync_q[0], pll_locked_i};
    filt_d = filt_q;
    if (!lock_s) begin
      filt_d = '0;
    end else if (filt_q != FMAX) begin
      filt_d = filt_q + FW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      filt_q <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/soc_reset_sequencer.sv
// Staged domain reset release and fetch enable sequencer.
// Ports: clk_sys, reset, pll_locked_i, sw_reset_req_i, fetch_hold_i
//   -> domain_rst_n_o, fetch_enable_o, ready_o, state_o, lock_loss_cnt_o.
module soc_reset_sequencer
  import soc_rst_pkg::*;
#(
  parameter int NUM_DOMAINS        = 2,
  parameter int LOCK_FILTER_CYCLES = 16,
  parameter int STAGE_DELAY        = 64,
  parameter int FETCH_DELAY        = 32,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   pll_locked_i,
  input  logic                   sw_reset_req_i,
  input  logic                   fetch_hold_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
  output logic                   fetch_enable_o,
  output logic                   ready_o,
  output logic [2:0]             state_o,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt_o
);

  localparam int CW  = cnt_width(STAGE_DELAY, FETCH_DELAY,
                                 LOCK_FILTER_CYCLES);
  localparam int SGW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0]  STG_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0]  FET_LAST = CW'(FETCH_DELAY - 1);
  localparam logic [SGW-1:0] DOM_LAST = SGW'(NUM_DOMAINS - 1);

  logic lock_s;
  logic lock_ok;

  lock_filter #(
    .LOCK_FILTER_CYCLES(LOCK_FILTER_CYCLES)
  ) u_lock_filter (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .pll_locked_i(pll_locked_i),
    .lock_s      (lock_s),
    .lock_ok     (lock_ok)
  );

  rst_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SGW-1:0]        stage_q, stage_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                  fen_q, fen_d;
  logic                  rdy_q, rdy_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  logic lost;
  logic sw_go;

  assign lost  = (state_q != WAIT_LOCK) && !lock_s;
  assign sw_go = sw_reset_req_i &&
                 ((state_q == RELEASE) ||
                  (state_q == FETCH_WAIT) ||
                  (state_q == RUN));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    dom_d   = dom_q;
    fen_d   = fen_q;
    rdy_d   = rdy_q;
    loss_d  = loss_q;
    if (lost) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      stage_d = '0;
      dom_d   = '0;
      fen_d   = 1'b0;
      rdy_d   = 1'b0;
      if (loss_q != {LOSS_CNT_W{1'b1}}) begin
        loss_d = loss_q + LOSS_CNT_W'(1);
      end
    end else if (sw_go) begin
      state_d = SW_HOLD;
      cnt_d   = '0;
      stage_d = '0;
      dom_d   = '0;
      fen_d   = 1'b0;
      rdy_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          dom_d = '0;
          fen_d = 1'b0;
          rdy_d = 1'b0;
          if (lock_ok) begin
            state_d = RELEASE;
            cnt_d   = '0;
            stage_d = '0;
          end
        end
        RELEASE: begin
          if (cnt_q == STG_LAST) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (stage_q == SGW'(i)) dom_d[i] = 1'b1;
            end
            if (stage_q == DOM_LAST) begin
              state_d = FETCH_WAIT;
              stage_d = '0;
            end else begin
              stage_d = stage_q + SGW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        FETCH_WAIT: begin
          if (cnt_q == FET_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            rdy_d   = 1'b1;
            fen_d   = !fetch_hold_i;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          rdy_d = 1'b1;
          fen_d = !fetch_hold_i;
        end
        SW_HOLD: begin
          // Lock is still good here, so skip the filter.
          if (cnt_q == STG_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          stage_d = '0;
          dom_d   = '0;
          fen_d   = 1'b0;
          rdy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      stage_q <= '0;
      dom_q   <= '0;
      fen_q   <= 1'b0;
      rdy_q   <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      dom_q   <= dom_d;
      fen_q   <= fen_d;
      rdy_q   <= rdy_d;
      loss_q  <= loss_d;
    end
  end

  assign domain_rst_n_o  = dom_q;
  assign fetch_enable_o  = fen_q;
  assign ready_o         = rdy_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Bench for soc_reset_sequencer: timed vector tables plus
// hand-written lock loss, software reset and async reset sequences.
module tb_soc_reset_sequencer;

  localparam int ND = 3;
  localparam int LW = 2;

  logic clk_sys        = 1'b0;
  logic reset          = 1'b0;
  logic pll_locked_i   = 1'b0;
  logic sw_reset_req_i = 1'b0;
  logic fetch_hold_i   = 1'b0;
  logic [ND-1:0] domain_rst_n_o;
  logic          fetch_enable_o;
  logic          ready_o;
  logic [2:0]    state_o;
  logic [LW-1:0] lock_loss_cnt_o;

  always #5 clk_sys = ~clk_sys;

  soc_reset_sequencer #(
    .NUM_DOMAINS       (ND),
    .LOCK_FILTER_CYCLES(4),
    .STAGE_DELAY       (8),
    .FETCH_DELAY       (5),
    .LOSS_CNT_W        (LW)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .pll_locked_i   (pll_locked_i),
    .sw_reset_req_i (sw_reset_req_i),
    .fetch_hold_i   (fetch_hold_i),
    .domain_rst_n_o (domain_rst_n_o),
    .fetch_enable_o (fetch_enable_o),
    .ready_o        (ready_o),
    .state_o        (state_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  typedef struct packed {
    logic [2:0] dom;
    logic       fen;
    logic       rdy;
    logic [2:0] st;
    logic [1:0] loss;
  } exp_t;

  typedef struct {
    int    e;
    logic  lock;
    logic  hold;
    exp_t  x;
    string nm;
  } vec_t;

  vec_t plan[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   now   = 0;

  function automatic exp_t mk(logic [2:0] d, logic f, logic r,
                              logic [2:0] s, logic [1:0] l);
    exp_t v;
    v.dom  = d;
    v.fen  = f;
    v.rdy  = r;
    v.st   = s;
    v.loss = l;
    return v;
  endfunction

  function automatic exp_t sample();
    return mk(domain_rst_n_o, fetch_enable_o, ready_o,
              state_o, lock_loss_cnt_o);
  endfunction

  task automatic check(string nm, exp_t w);
    exp_t a;
    a = sample();
    total++;
    if (a !== w) begin
      bad++;
      $display("FAIL %s: got dom=%b fen=%b rdy=%b st=%0d loss=%0d want dom=%b fen=%b rdy=%b st=%0d loss=%0d",
               nm, a.dom, a.fen, a.rdy, a.st, a.loss,
               w.dom, w.fen, w.rdy, w.st, w.loss);
    end
  endtask

  task automatic step_to(int t);
    if (t > now) begin
      repeat (t - now) @(posedge clk_sys);
      now = t;
      #2;
    end
  endtask

  task automatic mark();
    now = 0;
  endtask

  task automatic add(int e, logic lk, logic hd, exp_t x, string nm);
    vec_t v;
    v.e    = e;
    v.lock = lk;
    v.hold = hd;
    v.x    = x;
    v.nm   = nm;
    plan.push_back(v);
  endtask

  task automatic play();
    exp_t w;
    foreach (plan[i]) begin
      sb.push_back(plan[i].x);
      step_to(plan[i].e);
      w = sb.pop_front();
      check(plan[i].nm, w);
      pll_locked_i = plan[i].lock;
      fetch_hold_i = plan[i].hold;
    end
    plan.delete();
  endtask

  // Edges counted from the point lock is seen at the input.
  task automatic load_powerup(logic [1:0] l);
    add(6,  1, 0, mk(3'b000, 0, 0, 0, l), "wl_end");
    add(7,  1, 0, mk(3'b000, 0, 0, 1, l), "rel_entry");
    add(14, 1, 0, mk(3'b000, 0, 0, 1, l), "d0_pre");
    add(15, 1, 0, mk(3'b001, 0, 0, 1, l), "d0_rel");
    add(22, 1, 0, mk(3'b001, 0, 0, 1, l), "d1_pre");
    add(23, 1, 0, mk(3'b011, 0, 0, 1, l), "d1_rel");
    add(30, 1, 0, mk(3'b011, 0, 0, 1, l), "d2_pre");
    add(31, 1, 0, mk(3'b111, 0, 0, 2, l), "d2_rel");
    add(35, 1, 0, mk(3'b111, 0, 0, 2, l), "fw_end");
    add(36, 1, 0, mk(3'b111, 1, 1, 3, l), "run");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sat;
    pll_locked_i = 1'b1;
    #1 reset = 1'b1;
    #2 check("reset", mk(3'b000, 0, 0, 0, 0));
    repeat (3) @(posedge clk_sys);
    #2 reset = 1'b0;
    mark();
    load_powerup(2'd0);
    play();

    sw_reset_req_i = 1'b1;
    step_to(now + 1);
    check("sw_enter", mk(3'b000, 0, 0, 4, 0));
    sw_reset_req_i = 1'b0;
    fetch_hold_i   = 1'b1;
    mark();
    add(7,  1, 1, mk(3'b000, 0, 0, 4, 0), "sw_hold_end");
    add(8,  1, 1, mk(3'b000, 0, 0, 1, 0), "sw_rel");
    add(15, 1, 1, mk(3'b000, 0, 0, 1, 0), "sw_d0_pre");
    add(16, 1, 1, mk(3'b001, 0, 0, 1, 0), "sw_d0");
    add(24, 1, 1, mk(3'b011, 0, 0, 1, 0), "sw_d1");
    add(32, 1, 1, mk(3'b111, 0, 0, 2, 0), "sw_d2");
    add(37, 1, 0, mk(3'b111, 0, 1, 3, 0), "hold_run");
    add(38, 1, 0, mk(3'b111, 1, 1, 3, 0), "hold_drop");
    play();

    pll_locked_i = 1'b0;
    mark();
    step_to(2);
    check("loss_pre", mk(3'b111, 1, 1, 3, 0));
    step_to(3);
    check("loss_hit", mk(3'b000, 0, 0, 0, 1));
    step_to(4);
    check("loss_wl", mk(3'b000, 0, 0, 0, 1));
    pll_locked_i = 1'b1;
    mark();
    load_powerup(2'd1);
    play();

    for (int k = 2; k <= 4; k++) begin
      sat = (k > 3) ? 2'd3 : 2'(k);
      pll_locked_i = 1'b0;
      mark();
      step_to(3);
      check("loss_n", mk(3'b000, 0, 0, 0, sat));
      pll_locked_i = 1'b1;
      mark();
      step_to(7);
      check("relock", mk(3'b000, 0, 0, 1, sat));
    end

    step_to(15);
    check("mid_rel", mk(3'b001, 0, 0, 1, 3));
    #1 reset = 1'b1;
    #1 check("async_rst", mk(3'b000, 0, 0, 0, 0));
    repeat (2) @(posedge clk_sys);
    #2 reset = 1'b0;
    mark();
    add(2,  0, 0, mk(3'b000, 0, 0, 0, 0), "gl_drop");
    add(3,  1, 0, mk(3'b000, 0, 0, 0, 0), "gl_back");
    add(9,  1, 0, mk(3'b000, 0, 0, 0, 0), "gl_no_early");
    add(10, 1, 0, mk(3'b000, 0, 0, 1, 0), "gl_rel");
    add(17, 1, 0, mk(3'b000, 0, 0, 1, 0), "gl_d0_pre");
    add(18, 1, 0, mk(3'b001, 0, 0, 1, 0), "gl_d0");
    play();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
